mac_dft_engine: RTL and testbench
=================================

MAC_DFT_ENGINE -- requirements
Module: mac_dft_engine

Interface
REQ-001 Parameter DATA_W, default 16, is the signed sample and twiddle width (twiddle format Q1.(DATA_W-1)).
REQ-002 Parameter ADDR_W, default 12, is the index width; the maximum transform length is 2^ADDR_W-1.
REQ-003 Parameter ACC_W, default 2*DATA_W+ADDR_W, is the signed accumulator width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 n_Reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a transform, sampled in IDLE only.
REQ-007 samp_number  in  ADDR_W  transform length N, captured on the accepted start.
REQ-008 scale  in  4  extra output right-shift, captured on the accepted start.
REQ-009 smp_addr  out  ADDR_W  sample memory read index n.
REQ-010 smp_re, smp_im  in  DATA_W each  sample memory data, valid exactly one cycle after smp_addr.
REQ-011 tw_k, tw_n  out  ADDR_W each  twiddle ROM indices.
REQ-012 tw_re, tw_im  in  DATA_W each  twiddle data, valid exactly one cycle after tw_k/tw_n.
REQ-013 out_valid, out_ready  out/in  1 each  result stream handshake.
REQ-014 out_re, out_im  out  DATA_W each  bin result; out_k  out  ADDR_W  bin index; out_last  out  1  marks bin N-1.
REQ-015 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle completion pulse; err  out  1  sticky length error.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and OUT.
REQ-017 IDLE->RUN on start when 2 <= samp_number; this clears k, n, the accumulator and err.
REQ-018 start in IDLE with samp_number < 2: remain in IDLE, set err, no done pulse.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 RUN: one index per cycle; smp_addr = tw_n = n, tw_k = k; n increments 0..N-1.
REQ-021 Data is returned one cycle after each index; on that cycle acc += complex product, where re = xr*wr - xi*wi and im = xr*wi + xi*wr, computed at full 2*DATA_W+1 width and sign-extended to ACC_W.
REQ-022 RUN->DRAIN after issuing n = N-1; DRAIN lasts 1 cycle (last accumulate), then DRAIN->OUT.
REQ-023 OUT: out_valid=1; out_re/out_im = saturate_DATA_W((acc + 2^(s-1)) >>> s), with s = DATA_W-1+scale (arithmetic shift, round-half-up).
REQ-024 Saturation limits SHALL be -2^(DATA_W-1) and 2^(DATA_W-1)-1.
REQ-025 out_re, out_im, out_k and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Handshake in OUT with k<N-1: k++, n=0, accumulator cleared, ->RUN.
REQ-027 Handshake in OUT with k=N-1: ->IDLE, with done=1 for the following cycle.
REQ-028 Per-bin cost SHALL be N+2 cycles plus any out_ready stall; a full transform with out_ready tied high takes N*(N+2) cycles from start to the last handshake.
REQ-029 The accumulator SHALL wrap (no saturation); ACC_W default guarantees no overflow for N <= 2^ADDR_W-1.
REQ-030 smp_addr, tw_k and tw_n SHALL hold their last value outside RUN.

Reset
REQ-031 While n_Reset=0, regardless of clock: state=IDLE, k=n=0, accumulator=0.
REQ-032 While n_Reset=0, all outputs are 0, including out_valid, busy, done and err.
REQ-033 Reset asserted mid-transform SHALL abort it with no done pulse and no further out_valid.
REQ-034 After reset release, the first accepted start begins a clean transform.

Verification
REQ-035 DC: N=4, scale=2, x=(0x4000,0) for all n, ideal ROM -> bin0 (0x4000,0), bins1-3 (0,0), out_last on k=3, done one cycle after the 4th handshake, 24 cycles with ready high.
REQ-036 Impulse: N=8, x[0]=(0x2000,0), others 0, scale=0 -> all 8 bins (0x2000,0), out_k 0..7.
REQ-037 Saturation: N=16, scale=0, x=(0x7FFF,0x7FFF), tw=(0x7FFF,0) -> bin0 (0x7FFF,0x7FFF); inverted data -> (0x8000,0x8000).
REQ-038 Backpressure: out_ready low for 5 cycles in OUT -> outputs stable, next bin delayed exactly 5 cycles, results unchanged.
REQ-039 Length error and ignored start: start with samp_number=1 -> err=1, busy=0, no out_valid; start during RUN -> no effect on k, n or results.
REQ-040 Reset mid-run: n_Reset low during RUN of bin 2 -> all outputs 0 immediately; a new start with N=4 reproduces REQ-035.

Source files
------------

// File: rtl/mac_dft_engine.sv
// mac_dft_engine: direct-form DFT, one complex multiply-accumulate per cycle,
// one output bin per N+2 cycles, streamed out over a valid/ready handshake.
`default_nettype none

module mac_dft_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
  input  logic                     clk,
  input  logic                     n_Reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        samp_number,
  input  logic [3:0]               scale,
  output logic [ADDR_W-1:0]        smp_addr,
  input  logic signed [DATA_W-1:0] smp_re,
  input  logic signed [DATA_W-1:0] smp_im,
  output logic [ADDR_W-1:0]        tw_k,
  output logic [ADDR_W-1:0]        tw_n,
  input  logic signed [DATA_W-1:0] tw_re,
  input  logic signed [DATA_W-1:0] tw_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [ADDR_W-1:0]        out_k,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

  localparam int PROD_W = 2*DATA_W+1;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         k_q, k_d, n_q, n_d, len_q, len_d;
  logic [3:0]                scale_q, scale_d;
  logic signed [ACC_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                      vld_q, vld_d, done_q, done_d, err_q, err_d;

  logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PROD_W-1:0]   prod_re, prod_im;
  logic signed [ACC_W-1:0]    ext_re, ext_im;
  logic                       last_n, last_k;

  assign p_rr    = smp_re * tw_re;
  assign p_ii    = smp_im * tw_im;
  assign p_ri    = smp_re * tw_im;
  assign p_ir    = smp_im * tw_re;
  assign prod_re = {p_rr[2*DATA_W-1], p_rr} - {p_ii[2*DATA_W-1], p_ii};
  assign prod_im = {p_ri[2*DATA_W-1], p_ri} + {p_ir[2*DATA_W-1], p_ir};
  assign ext_re  = {{(ACC_W-PROD_W){prod_re[PROD_W-1]}}, prod_re};
  assign ext_im  = {{(ACC_W-PROD_W){prod_im[PROD_W-1]}}, prod_im};

  assign last_n = (n_q == len_q - ADDR_W'(1));
  assign last_k = (k_q == len_q - ADDR_W'(1));

  // Round half up at bit s-1, arithmetic shift by s = DATA_W-1+scale, then clamp.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a,
                                                         input logic [3:0] sc);
    logic [5:0]              s;
    logic signed [ACC_W:0]   half, w;
    s    = 6'(DATA_W-1) + {2'b00, sc};
    half = {{ACC_W{1'b0}}, 1'b1} << (s - 6'd1);
    w    = {a[ACC_W-1], a} + half;
    w    = w >>> s;
    if (w > SAT_MAX)      w = SAT_MAX;
    else if (w < SAT_MIN) w = SAT_MIN;
    return w[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      len_q    <= '0;
      scale_q  <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      len_q    <= len_d;
      scale_q  <= scale_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    len_d    = len_q;
    scale_d  = scale_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;

    // vld_q marks the cycle on which data for the previously issued index returns.
    if (vld_q) begin
      acc_re_d = acc_re_q + ext_re;
      acc_im_d = acc_im_q + ext_im;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (samp_number >= ADDR_W'(2)) begin
            state_d  = RUN;
            k_d      = '0;
            n_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            err_d    = 1'b0;
            len_d    = samp_number;
            scale_d  = scale;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        vld_d = 1'b1;
        if (last_n) state_d = DRAIN;
        else        n_d     = n_q + ADDR_W'(1);
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (last_k) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            k_d      = k_q + ADDR_W'(1);
            n_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign smp_addr  = n_q;
  assign tw_n      = n_q;
  assign tw_k      = k_q;
  assign out_k     = k_q;
  assign out_valid = (state_q == OUT);
  assign out_last  = out_valid && last_k;
  assign out_re    = out_valid ? round_sat(acc_re_q, scale_q) : '0;
  assign out_im    = out_valid ? round_sat(acc_im_q, scale_q) : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_dft_engine.sv
// Randomized self-checking bench for mac_dft_engine against a direct DFT reference model.
`default_nettype none

module tb_mac_dft_engine;
  localparam int DW = 16;
  localparam int AW = 12;

  logic                 clk = 1'b0;
  logic                 n_Reset = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        samp_number = '0;
  logic [3:0]           scale = '0;
  logic [AW-1:0]        smp_addr, tw_k, tw_n, out_k;
  logic signed [DW-1:0] smp_re = '0, smp_im = '0, tw_re = '0, tw_im = '0;
  logic signed [DW-1:0] out_re, out_im;
  logic                 out_valid, out_last, busy, done, err;
  logic                 out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] mem_re [0:4095];
  logic signed [DW-1:0] mem_im [0:4095];
  int     tw_mode = 0;
  int     cur_n   = 4;
  longint exp_re [0:15];
  longint exp_im [0:15];

  mac_dft_engine dut (
    .clk(clk), .n_Reset(n_Reset), .start(start), .samp_number(samp_number), .scale(scale),
    .smp_addr(smp_addr), .smp_re(smp_re), .smp_im(smp_im),
    .tw_k(tw_k), .tw_n(tw_n), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_k(out_k), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Twiddle W_N^(k*n) = exp(-j*2*pi*k*n/N) in Q1.15, or a constant (0x7FFF, 0).
  function automatic longint tw_val(input int k, input int n, input int nn, input bit im);
    real ang, v;
    if (tw_mode == 1) return im ? 64'sd0 : 64'sd32767;
    ang = -2.0 * 3.14159265358979 * real'(k * n) / real'(nn);
    v   = (im ? $sin(ang) : $cos(ang)) * 32767.0;
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    return -longint'($rtoi(-v + 0.5));
  endfunction

  // Synchronous sample RAM and twiddle ROM, one cycle read latency.
  always @(posedge clk) begin
    smp_re <= mem_re[smp_addr];
    smp_im <= mem_im[smp_addr];
    tw_re  <= 16'(tw_val(int'(tw_k), int'(tw_n), cur_n, 1'b0));
    tw_im  <= 16'(tw_val(int'(tw_k), int'(tw_n), cur_n, 1'b1));
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint rsat(input longint a, input int s);
    longint r;
    r = (a + (longint'(1) <<< (s - 1))) >>> s;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model(input int nn, input int sc);
    longint ar, ai, xr, xi, wr, wi;
    for (int k = 0; k < nn; k++) begin
      ar = 0;
      ai = 0;
      for (int n = 0; n < nn; n++) begin
        xr = mem_re[n];
        xi = mem_im[n];
        wr = tw_val(k, n, nn, 1'b0);
        wi = tw_val(k, n, nn, 1'b1);
        ar += xr * wr - xi * wi;
        ai += xr * wi + xi * wr;
      end
      exp_re[k] = rsat(ar, 15 + sc);
      exp_im[k] = rsat(ai, 15 + sc);
    end
  endtask

  task automatic fill(input int nn, input int r, input int i);
    for (int n = 0; n < 4096; n++) begin
      mem_re[n] = (n < nn) ? 16'(r) : 16'sd0;
      mem_im[n] = (n < nn) ? 16'(i) : 16'sd0;
    end
  endtask

  // stall_mode >= 0: hold ready low that many cycles on bin 0; -1: random 0..3 per bin.
  task automatic run_xform(input int nn, input int sc, input int stall_mode, input bit inject);
    int edges, bin, stall, total_stall, hs_edge;
    logic signed [DW-1:0] h_re, h_im;
    logic [AW-1:0]        h_k;
    logic                 h_last;
    cur_n = nn;
    model(nn, sc);
    @(negedge clk);
    samp_number = AW'(nn);
    scale       = 4'(sc);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    samp_number = AW'($urandom_range(0, 4095));
    scale       = 4'($urandom_range(0, 15));
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    edges = 0; bin = 0; stall = -1; total_stall = 0; hs_edge = 0;
    h_re = '0; h_im = '0; h_k = '0; h_last = 1'b0;
    while (bin < nn && edges < 4000) begin
      start = inject && (edges == 3);
      if (out_valid) begin
        if (stall < 0) begin
          stall = (stall_mode < 0) ? int'($urandom_range(0, 3)) : ((bin == 0) ? stall_mode : 0);
          total_stall += stall;
          h_re = out_re; h_im = out_im; h_k = out_k; h_last = out_last;
          chk("bin_re", out_re, exp_re[bin]);
          chk("bin_im", out_im, exp_im[bin]);
          chk("bin_k", out_k, bin);
          chk("bin_last", out_last, (bin == nn - 1) ? 1 : 0);
        end else begin
          chk("hold_re", out_re, h_re);
          chk("hold_im", out_im, h_im);
          chk("hold_k", out_k, h_k);
          chk("hold_last", out_last, h_last);
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          hs_edge   = edges + 1;
          bin++;
          stall     = -1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("bins_seen", bin, nn);
    chk("xform_cycles", hs_edge, nn * (nn + 2) + total_stall);
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  task automatic len_error(input int nn);
    @(negedge clk);
    samp_number = AW'(nn);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lenerr_err", err, 1);
    chk("lenerr_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("lenerr_valid", out_valid, 0);
      chk("lenerr_done", done, 0);
      @(negedge clk);
    end
    chk("lenerr_sticky", err, 1);
  endtask

  initial begin
    int nn, sc;
    fill(0, 0, 0);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_re", out_re, 0);
    chk("rst_addr", smp_addr, 0);
    repeat (3) @(negedge clk);
    n_Reset = 1'b1;

    // DC input: energy only in bin 0, exactly N*(N+2) cycles.
    tw_mode = 0;
    fill(4, 16'h4000, 0);
    run_xform(4, 2, 0, 1'b0);

    len_error(1);
    len_error(0);

    // Impulse at n=0: flat spectrum.
    fill(0, 0, 0);
    mem_re[0] = 16'sh2000;
    run_xform(8, 0, 0, 1'b0);

    // Backpressure on bin 0.
    fill(4, 16'h4000, 0);
    run_xform(4, 2, 5, 1'b0);

    // Saturation both directions.
    tw_mode = 1;
    fill(16, 16'h7FFF, 16'h7FFF);
    run_xform(16, 0, 0, 1'b0);
    fill(16, 16'h8001, 16'h8001);
    run_xform(16, 0, 0, 1'b0);

    // Random data, length, scale and stalls; a stray start mid-run on some.
    tw_mode = 0;
    for (int t = 0; t < 6; t++) begin
      nn = int'($urandom_range(4, 12));
      sc = int'($urandom_range(0, 3));
      for (int n = 0; n < 4096; n++) begin
        mem_re[n] = (n < nn) ? 16'($urandom) : 16'sd0;
        mem_im[n] = (n < nn) ? 16'($urandom) : 16'sd0;
      end
      run_xform(nn, sc, -1, (t % 2) == 1);
    end

    // Reset asserted during RUN of bin 2.
    fill(4, 16'h4000, 0);
    cur_n = 4;
    @(negedge clk);
    samp_number = AW'(4);
    scale       = 4'd2;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(busy && !out_valid && tw_k == 2) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("reach_bin2", guard < 200, 1);
    end
    #1 n_Reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_k", tw_k, 0);
    chk("mid_rst_addr", smp_addr, 0);
    chk("mid_rst_re", out_re, 0);
    repeat (3) @(negedge clk);
    n_Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_done", done, 0);
      @(negedge clk);
    end
    run_xform(4, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
